noise_gate: RTL



---
 rtl/noise_gate.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/noise_gate.sv
// -----------------------------------------------------------------------------
// noise_gate
//
// Input-side noise gate that sits directly ahead of the distortion stage. It
// keeps a decaying peak envelope of the incoming signed samples. A
// CLOSED/ATTACK/OPEN/HOLD/RELEASE state machine drives a 9-bit gain, where 256
// means unity. The ramped gain is applied to each sample, so pickup hiss and
// hum are removed before the distortion stage can amplify them.
//
// Latency is fixed at two cycles from the input strobe to the output strobe:
//   cycle n   : audio_ready=1, x is captured
//   cycle n+1 : envelope, state, gain and hold counter update; y is computed
//   cycle n+2 : y / y_ready / indicator are presented
//
// Ports
//   CLK         in   clock
//   rst         in   synchronous active-high reset (wins over everything)
//   en          in   1 = gate active, 0 = bypass (y = x, gate parked OPEN)
//   x           in   signed input sample
//   audio_ready in   one-cycle strobe, x valid
//   y           out  gated signed sample (holds between strobes)
//   y_ready     out  one-cycle strobe, y valid
//   indicator   out  1 when the gain applied to y is non-zero
//
// Optional build macro NOISE_GATE_DEBUG_EN adds two more outputs:
//   env_out     out  envelope after the latest sample update
//   state_out   out  gate state (CLOSED=0 ATTACK=1 OPEN=2 HOLD=3 RELEASE=4)
// -----------------------------------------------------------------------------
module noise_gate #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] THRESH_OPEN  = 32'h00080000,
  parameter logic [DATA_WIDTH-1:0] THRESH_CLOSE = 32'h00040000,
  parameter logic [15:0]           HOLD_SAMPLES = 16'd4800,
  parameter logic [8:0]            ATTACK_STEP  = 9'd32,
  parameter logic [8:0]            RELEASE_STEP = 9'd1,
  parameter int                    DECAY_SHIFT  = 10
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic                  audio_ready,
`ifdef NOISE_GATE_DEBUG_EN
  output logic [DATA_WIDTH-1:0] env_out,
  output logic [2:0]            state_out,
`endif
  output logic [DATA_WIDTH-1:0] y,
  output logic                  y_ready,
  output logic                  indicator
);

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } gate_state_t;

  localparam logic [8:0] GAIN_UNITY = 9'd256;

  // Magnitude with the most-negative code clamped to the largest positive value.
  function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] most_neg;
    logic [DATA_WIDTH-1:0] r;
    most_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    if (v == most_neg) begin
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (v[DATA_WIDTH-1]) begin
      r = ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Capture stage
  logic [DATA_WIDTH-1:0] x_cap_r;
  logic                  en_cap_r;
  logic                  vld_cap_r;

  // Gate state
  gate_state_t           state_r;
  gate_state_t           state_next_s;
  logic [DATA_WIDTH-1:0] env_r;
  logic [8:0]            gain_r;
  logic [15:0]           hold_cnt_r;

  // Output registers
  logic [DATA_WIDTH-1:0] y_r;
  logic                  y_ready_r;
  logic                  indicator_r;

  // Combinational datapath
  logic [DATA_WIDTH-1:0] absx_s;
  logic [DATA_WIDTH-1:0] decayed_s;
  logic [DATA_WIDTH-1:0] env_next_s;
  logic                  open_hit_s;
  logic                  close_hit_s;
  logic [9:0]            gain_sum_s;
  logic [8:0]            gain_up_s;
  logic [8:0]            gain_dn_s;
  logic [8:0]            gain_next_s;
  logic [15:0]           hold_next_s;
  logic signed [DATA_WIDTH+9:0] x_ext_s;
  logic signed [DATA_WIDTH+9:0] g_ext_s;
  logic signed [DATA_WIDTH+9:0] prod_s;
  logic [DATA_WIDTH-1:0] y_next_s;

  // Envelope follower and the saturating gain-ramp arithmetic.
  always_comb begin
    absx_s    = abs_sat(x_cap_r);
    decayed_s = env_r - (env_r >> DECAY_SHIFT);
    if (absx_s > decayed_s) begin
      env_next_s = absx_s;
    end else begin
      env_next_s = decayed_s;
    end
    open_hit_s  = (env_next_s >= THRESH_OPEN);
    close_hit_s = (env_next_s < THRESH_CLOSE);

    gain_sum_s = {1'b0, gain_r} + {1'b0, ATTACK_STEP};
    if (gain_sum_s >= {1'b0, GAIN_UNITY}) begin
      gain_up_s = GAIN_UNITY;
    end else begin
      gain_up_s = gain_sum_s[8:0];
    end

    if (gain_r > RELEASE_STEP) begin
      gain_dn_s = gain_r - RELEASE_STEP;
    end else begin
      gain_dn_s = 9'd0;
    end
  end

  // Next-state logic; evaluated against the envelope including this sample.
  always_comb begin
    state_next_s = state_r;
    if (!en_cap_r) begin
      state_next_s = ST_OPEN;
    end else begin
      case (state_r)
        ST_CLOSED: begin
          if (open_hit_s) begin
            state_next_s = (gain_up_s == GAIN_UNITY) ? ST_OPEN : ST_ATTACK;
          end else begin
            state_next_s = ST_CLOSED;
          end
        end
        ST_ATTACK: begin
          if (close_hit_s) begin
            state_next_s = ST_RELEASE;
          end else if (gain_up_s == GAIN_UNITY) begin
            state_next_s = ST_OPEN;
          end else begin
            state_next_s = ST_ATTACK;
          end
        end
        ST_OPEN: begin
          if (close_hit_s) begin
            state_next_s = ST_HOLD;
          end else begin
            state_next_s = ST_OPEN;
          end
        end
        ST_HOLD: begin
          // A count of 1 reaches zero on this sample; a count of 0 means
          // HOLD_SAMPLES was zero and we leave on the first HOLD sample.
          if (open_hit_s) begin
            state_next_s = ST_OPEN;
          end else if (hold_cnt_r <= 16'd1) begin
            state_next_s = ST_RELEASE;
          end else begin
            state_next_s = ST_HOLD;
          end
        end
        ST_RELEASE: begin
          if (open_hit_s) begin
            state_next_s = (gain_up_s == GAIN_UNITY) ? ST_OPEN : ST_ATTACK;
          end else if (gain_dn_s == 9'd0) begin
            state_next_s = ST_CLOSED;
          end else begin
            state_next_s = ST_RELEASE;
          end
        end
        default: begin
          state_next_s = ST_CLOSED;
        end
      endcase
    end
  end

  // Gain, hold counter and gated sample for the sample in the capture stage.
  always_comb begin
    gain_next_s = gain_r;
    hold_next_s = hold_cnt_r;
    if (!en_cap_r) begin
      gain_next_s = GAIN_UNITY;
      hold_next_s = 16'd0;
    end else begin
      case (state_r)
        ST_CLOSED: begin
          hold_next_s = 16'd0;
          if (open_hit_s) begin
            gain_next_s = gain_up_s;
          end else begin
            gain_next_s = 9'd0;
          end
        end
        ST_ATTACK: begin
          // Losing the signal mid-attack freezes the gain for this sample.
          if (close_hit_s) begin
            gain_next_s = gain_r;
          end else begin
            gain_next_s = gain_up_s;
          end
        end
        ST_OPEN: begin
          gain_next_s = GAIN_UNITY;
          if (close_hit_s) begin
            hold_next_s = HOLD_SAMPLES;
          end else begin
            hold_next_s = hold_cnt_r;
          end
        end
        ST_HOLD: begin
          gain_next_s = GAIN_UNITY;
          if (open_hit_s || (hold_cnt_r <= 16'd1)) begin
            hold_next_s = 16'd0;
          end else begin
            hold_next_s = hold_cnt_r - 16'd1;
          end
        end
        ST_RELEASE: begin
          // Re-attack resumes from the current gain, so no jump to zero.
          if (open_hit_s) begin
            gain_next_s = gain_up_s;
          end else begin
            gain_next_s = gain_dn_s;
          end
        end
        default: begin
          gain_next_s = 9'd0;
          hold_next_s = 16'd0;
        end
      endcase
    end

    // Signed x times non-negative gain. A gain of at most 256 keeps the
    // result of the >>> 8 inside DATA_WIDTH, so the truncation is exact.
    x_ext_s  = {{10{x_cap_r[DATA_WIDTH-1]}}, x_cap_r};
    g_ext_s  = {{(DATA_WIDTH+1){1'b0}}, gain_next_s};
    prod_s   = x_ext_s * g_ext_s;
    y_next_s = DATA_WIDTH'(prod_s >>> 8);
  end

  // Pipeline, gate state and output registers; rst clears everything.
  always_ff @(posedge CLK) begin
    if (rst) begin
      x_cap_r     <= {DATA_WIDTH{1'b0}};
      en_cap_r    <= 1'b0;
      vld_cap_r   <= 1'b0;
      state_r     <= ST_CLOSED;
      env_r       <= {DATA_WIDTH{1'b0}};
      gain_r      <= 9'd0;
      hold_cnt_r  <= 16'd0;
      y_r         <= {DATA_WIDTH{1'b0}};
      y_ready_r   <= 1'b0;
      indicator_r <= 1'b0;
    end else begin
      vld_cap_r <= audio_ready;
      if (audio_ready) begin
        x_cap_r  <= x;
        en_cap_r <= en;
      end
      y_ready_r <= vld_cap_r;
      if (vld_cap_r) begin
        state_r     <= state_next_s;
        env_r       <= env_next_s;
        gain_r      <= gain_next_s;
        hold_cnt_r  <= hold_next_s;
        y_r         <= y_next_s;
        indicator_r <= (gain_next_s != 9'd0);
      end
    end
  end

`ifdef NOISE_GATE_DEBUG_EN
  logic [DATA_WIDTH-1:0] env_out_r;
  logic [2:0]            state_out_r;

  // Debug view of envelope and state, updated with the gate state.
  always_ff @(posedge CLK) begin
    if (rst) begin
      env_out_r   <= {DATA_WIDTH{1'b0}};
      state_out_r <= 3'd0;
    end else if (vld_cap_r) begin
      env_out_r   <= env_next_s;
      state_out_r <= state_next_s;
    end
  end

  assign env_out   = env_out_r;
  assign state_out = state_out_r;
`endif

  assign y         = y_r;
  assign y_ready   = y_ready_r;
  assign indicator = indicator_r;

endmodule
